stream_fifo_buf: RTL and testbench

- Elastic FIFO that sits directly downstream of the N-way round-robin arbitration tree.
- It absorbs the arbitrated valid/data stream, decouples arbiter grant timing from the consumer, and re-issues words in arrival order.
- It provides occupancy status: count, almost_full, and a high-water mark used for sizing.
- It is first-word-fall-through with a registered output, and it has no combinational path from input to output.

---
 rtl/stream_fifo_mem.sv | 27 ++
 rtl/stream_fifo_buf.sv | 101 ++++++++++
 tb/tb_stream_fifo_buf.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/stream_fifo_mem.sv
// Storage array for stream_fifo_buf: one synchronous write port and one
// asynchronous read port, kept separate so it can be mapped to LUTRAM/BRAM.
module stream_fifo_mem #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  // Contents are intentionally not reset.
  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo_buf.sv
// Elastic first-word-fall-through FIFO behind the round-robin arbiter tree,
// with occupancy status (count, almost_full, empty) and a high-water mark.
module stream_fifo_buf #(
  parameter int DWIDTH   = 16,
  parameter int DEPTH    = 8,
  parameter int AFULL_TH = 6,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready,
  output logic [CW-1:0]     count,
  output logic              almost_full,
  output logic              empty,
  output logic [CW-1:0]     hwm
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("stream_fifo_buf: DEPTH must be a power of 2 and at least 2");
  end
  if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_bad_afull
    $error("stream_fifo_buf: AFULL_TH must be in 1..DEPTH");
  end

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     hwm_q;
  logic [CW-1:0]     next_count;
  logic [DWIDTH-1:0] rd_data;
  logic              push;
  logic              pop;

  // Valid/ready: a word moves on an edge where valid and ready are both high.
  // in_ready depends only on registered count, so a pop never frees a slot
  // for a push in the same cycle (no out_ready -> in_ready path).
  assign in_ready    = (count_q != CW'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign count       = count_q;
  assign hwm         = hwm_q;
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CW'(AFULL_TH));
  assign out_data    = out_valid ? rd_data : '0;

  always_comb begin
    next_count = count_q;
    if (flush) begin
      next_count = '0;
    end else if (push && !pop) begin
      next_count = count_q + CW'(1);
    end else if (pop && !push) begin
      next_count = count_q - CW'(1);
    end
  end

  // Flush wins over push/pop; since next_count is 0 then, hwm is untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      hwm_q   <= '0;
    end else begin
      count_q <= next_count;
      if (next_count > hwm_q) begin
        hwm_q <= next_count;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  stream_fifo_mem #(
    .DWIDTH (DWIDTH),
    .DEPTH  (DEPTH),
    .AW     (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata (in_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_stream_fifo_buf.sv
// Directed bench for stream_fifo_buf: scoreboard queue of expected words,
// negedge monitor, and hand-computed status checks at key points.
module tb_stream_fifo_buf;

  localparam int DWIDTH   = 16;
  localparam int DEPTH    = 8;
  localparam int AFULL_TH = 6;
  localparam int CW       = $clog2(DEPTH + 1);

  logic              clk;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DWIDTH-1:0] out_data;
  logic              out_ready;
  logic [CW-1:0]     count;
  logic              almost_full;
  logic              empty;
  logic [CW-1:0]     hwm;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DWIDTH-1:0] exp_q[$];
  int m_count;
  int m_hwm;

  stream_fifo_buf #(
    .DWIDTH   (DWIDTH),
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full),
    .empty       (empty),
    .hwm         (hwm)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int model_next(input int c, input bit psh, input bit pp, input bit fl);
    if (fl) return 0;
    return c + (psh ? 1 : 0) - (pp ? 1 : 0);
  endfunction

  // Reference model: tracks occupancy/hwm and the expected word order.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_count <= 0;
      m_hwm   <= 0;
      exp_q.delete();
    end else begin
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_count != 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && m_count != DEPTH) exp_q.push_back(in_data);
      end
      m_count <= model_next(m_count, in_valid && m_count != DEPTH,
                            m_count != 0 && out_ready, flush);
      if (model_next(m_count, in_valid && m_count != DEPTH,
                     m_count != 0 && out_ready, flush) > m_hwm)
        m_hwm <= model_next(m_count, in_valid && m_count != DEPTH,
                            m_count != 0 && out_ready, flush);
    end
  end

  // Monitor: compare DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    chk("mon_out_valid", 32'(out_valid), 32'(m_count != 0));
    chk("mon_in_ready", 32'(in_ready), 32'(m_count != DEPTH));
    chk("mon_count", 32'(count), 32'(m_count));
    chk("mon_hwm", 32'(hwm), 32'(m_hwm));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL mon_out_data: got 0x%0h with no expected word queued", out_data);
      end else begin
        chk("mon_out_data", 32'(out_data), 32'(exp_q[0]));
      end
    end else begin
      chk("mon_out_data_idle", 32'(out_data), 32'h0);
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_hwm", 32'(hwm), 32'd0);
    reset = 1'b0;
    step();

    // Single word
    in_valid = 1'b1; in_data = 16'h00A5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_count1", 32'(count), 32'd1);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'h00A5);
    step();
    chk("single_count0", 32'(count), 32'd0);
    chk("single_hwm", 32'(hwm), 32'd1);
    chk("single_empty", 32'(empty), 32'd1);

    // Fill to full
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      step();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_afull", 32'(almost_full), 32'(i >= 6));
      chk("fill_in_ready", 32'(in_ready), 32'(i != 8));
    end
    in_data = 16'h0009;
    step();
    chk("full_hold_count", 32'(count), 32'd8);
    chk("full_head", 32'(out_data), 32'h0001);

    // Full with concurrent pop: pop only, then push+pop
    out_ready = 1'b1;
    step();
    chk("full_pop_count", 32'(count), 32'd7);
    step();
    chk("pushpop_count", 32'(count), 32'd7);
    chk("pushpop_head", 32'(out_data), 32'h0003);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("drain_empty", 32'(empty), 32'd1);
    chk("fill_hwm", 32'(hwm), 32'd8);

    // Wrap-around from a fresh reset
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 16'h0100 + 16'(i);
      step();
      chk("wrap_count", 32'(count), 32'd1);
      chk("wrap_data", 32'(out_data), 32'h0100 + 32'(i));
    end
    in_valid = 1'b0;
    step();
    chk("wrap_count0", 32'(count), 32'd0);
    chk("wrap_hwm", 32'(hwm), 32'd1);

    // Flush with a word offered in the same cycle
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 16'h0200 + 16'(i);
      step();
    end
    chk("preflush_count", 32'(count), 32'd5);
    flush = 1'b1; in_data = 16'hDEAD;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_hwm", 32'(hwm), 32'd5);
    step();
    chk("flush_dropped", 32'(count), 32'd0);

    // Async reset mid-operation
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'h0300 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    chk("prereset_count", 32'(count), 32'd4);
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", 32'(out_valid), 32'd0);
    chk("areset_in_ready", 32'(in_ready), 32'd1);
    chk("areset_hwm", 32'(hwm), 32'd0);
    chk("areset_count", 32'(count), 32'd0);
    chk("areset_data", 32'(out_data), 32'd0);
    #1 reset = 1'b0;
    in_valid = 1'b1; in_data = 16'h0BEE; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("resume_count", 32'(count), 32'd1);
    chk("resume_data", 32'(out_data), 32'h0BEE);
    step();
    chk("resume_empty", 32'(empty), 32'd1);
    chk("resume_hwm", 32'(hwm), 32'd1);
    step();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
